// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe.
// The master is the producer/consumer side; the slave is the ALU.
interface alu_pipe_if #(
   parameter int WIDTH = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [2:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_ovf;
   logic [2:0]       flags;

   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_data, out_ovf, flags
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_data, out_ovf, flags
   );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU (8 WISC ops) with a {Z,V,N} flag register updated on retire.
// Define ALU_SAT_EN to make ADD/SUB saturate on signed overflow instead of wrapping.
module alu_pipe #(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic      clk,
   input  logic      rst_n,
   alu_pipe_if.slave bus_io
);
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_RED  = 3'b011;
   localparam logic [2:0] OP_SLL  = 3'b100;
   localparam logic [2:0] OP_SRA  = 3'b101;
   localparam logic [2:0] OP_ROR  = 3'b110;
   localparam logic [2:0] OP_PADD = 3'b111;

   localparam int NUM_LANES = WIDTH / 4;
   localparam int NUM_BYTES = WIDTH / 8;
   localparam int MSB       = WIDTH - 1;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [2:0]       op;
   } req_t;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             ovf;
      logic [2:0]       op;
   } rsp_t;

   logic [2:1] vld_pipe_q, vld_pipe_d;
   req_t       s1_q, s1_d;
   rsp_t       s2_q, s2_d;
   logic [2:0] flags_q, flags_d;
   logic       adv1, adv2, retire;

   assign adv2   = !vld_pipe_q[2] || bus_io.out_ready;
   assign adv1   = !vld_pipe_q[1] || adv2;
   assign retire = vld_pipe_q[2] && bus_io.out_ready;

   assign bus_io.in_ready  = adv1;
   assign bus_io.out_valid = vld_pipe_q[2];
   assign bus_io.out_data  = s2_q.data;
   assign bus_io.out_ovf   = s2_q.ovf;
   assign bus_io.flags     = flags_q;

   // ---------------- stage-2 datapath, fed from the stage-1 registers
   logic [WIDTH-1:0]   sum, diff, arith, arith_r;
   logic [WIDTH-1:0]   xor_r, sll_r, sra_r, ror_r, red_r, padd_r, res;
   logic [2*WIDTH-1:0] rot_w;
   logic [SHAMT_W-1:0] sh;
   logic               is_sub, ovf_add, ovf_sub, ovf, ovf_r;

   assign sum     = s1_q.a + s1_q.b;
   assign diff    = s1_q.a - s1_q.b;
   assign ovf_add = (s1_q.a[MSB] == s1_q.b[MSB]) && (sum[MSB]  != s1_q.a[MSB]);
   assign ovf_sub = (s1_q.a[MSB] != s1_q.b[MSB]) && (diff[MSB] != s1_q.a[MSB]);
   assign is_sub  = (s1_q.op == OP_SUB);
   assign arith   = is_sub ? diff : sum;
   assign ovf     = is_sub ? ovf_sub : ovf_add;

`ifdef ALU_SAT_EN
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   // Overflow direction follows A's sign: A >= 0 can only overflow upward.
   assign arith_r = ovf ? (s1_q.a[MSB] ? SAT_MIN : SAT_MAX) : arith;
`else
   assign arith_r = arith;
`endif

   assign xor_r = s1_q.a ^ s1_q.b;
   assign sh    = s1_q.b[SHAMT_W-1:0];
   assign sll_r = s1_q.a << sh;
   assign sra_r = $signed(s1_q.a) >>> sh;
   assign rot_w = {s1_q.a, s1_q.a} >> sh;
   assign ror_r = rot_w[WIDTH-1:0];

   always_comb begin
      red_r = '0;
      for (int i = 0; i < NUM_BYTES; i++) begin
         red_r = red_r + {{(WIDTH-8){s1_q.a[8*i+7]}}, s1_q.a[8*i +: 8]}
                       + {{(WIDTH-8){s1_q.b[8*i+7]}}, s1_q.b[8*i +: 8]};
      end
   end

   logic [NUM_LANES-1:0][3:0] pa_a, pa_b, pa_r;
   assign pa_a = s1_q.a;
   assign pa_b = s1_q.b;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      logic [4:0] s;
      assign s       = {pa_a[g][3], pa_a[g]} + {pa_b[g][3], pa_b[g]};
      assign pa_r[g] = (s[4] != s[3]) ? (s[4] ? 4'h8 : 4'h7) : s[3:0];
   end
   assign padd_r = pa_r;

   always_comb begin
      res   = arith_r;
      ovf_r = 1'b0;
      case (s1_q.op)
         OP_ADD, OP_SUB: begin res = arith_r; ovf_r = ovf; end
         OP_XOR:  res = xor_r;
         OP_RED:  res = red_r;
         OP_SLL:  res = sll_r;
         OP_SRA:  res = sra_r;
         OP_ROR:  res = ror_r;
         OP_PADD: res = padd_r;
         default: res = arith_r;
      endcase
   end

   // ---------------- next state
   always_comb begin
      vld_pipe_d = vld_pipe_q;
      s1_d       = s1_q;
      s2_d       = s2_q;
      flags_d    = flags_q;
      if (adv1) begin
         vld_pipe_d[1] = bus_io.in_valid;
         if (bus_io.in_valid) begin
            s1_d.a  = bus_io.in_a;
            s1_d.b  = bus_io.in_b;
            s1_d.op = bus_io.in_op;
         end
      end
      if (adv2) begin
         vld_pipe_d[2] = vld_pipe_q[1];
         if (vld_pipe_q[1]) begin
            s2_d.data = res;
            s2_d.ovf  = ovf_r;
            s2_d.op   = s1_q.op;
         end
      end
      // Flags track only the retiring op, never the one being accepted.
      if (retire) begin
         case (s2_q.op)
            OP_ADD, OP_SUB:
               flags_d = {(s2_q.data == '0), s2_q.ovf, s2_q.data[MSB]};
            OP_XOR, OP_SLL, OP_SRA, OP_ROR:
               flags_d[2] = (s2_q.data == '0);
            default: flags_d = flags_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_pipe_q <= '0;
         s1_q       <= '0;
         s2_q       <= '0;
         flags_q    <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         flags_q    <= flags_d;
      end
   end
endmodule
